// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data responder: FSM encoding and
// the set of byte-lane select patterns the responder accepts.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [3:0] SEL_B0 = 4'b0001;
    localparam logic [3:0] SEL_B1 = 4'b0010;
    localparam logic [3:0] SEL_B2 = 4'b0100;
    localparam logic [3:0] SEL_B3 = 4'b1000;
    localparam logic [3:0] SEL_H0 = 4'b0011;
    localparam logic [3:0] SEL_H1 = 4'b1100;
    localparam logic [3:0] SEL_W  = 4'b1111;

    function automatic logic legal_sel(input logic [3:0] sel);
        case (sel)
            SEL_B0, SEL_B1, SEL_B2, SEL_B3,
            SEL_H0, SEL_H1, SEL_W: legal_sel = 1'b1;
            default:               legal_sel = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port 2^ADDR_WIDTH x 32 RAM with per-byte write enables and a
// registered read port that only updates when a read is requested.
import dmem_pkg::*;

module dmem_bram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem [2**ADDR_WIDTH];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Holding the read register between loads lets rdata_o persist across stores.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data port responder: latches one request, waits WAIT_CYCLES,
// performs the RAM access, then pulses ready_o for one cycle.
import dmem_pkg::*;

module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        stall_o
);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic                  rzero_q, rzero_d;
    logic                  we_q, we_d;
    logic                  bad_q, bad_d;
    logic [ADDR_WIDTH-1:0] word_q, word_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            sel_q, sel_d;

    logic                  req_bad;
    logic                  ram_re;
    logic [3:0]            ram_we;
    logic [31:0]           ram_rdata;

    assign req_bad = !legal_sel(sel_i) || ((addr_i >> (ADDR_WIDTH + 2)) != 32'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        err_d   = err_q;
        rzero_d = rzero_q;
        we_d    = we_q;
        bad_d   = bad_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        ram_re  = 1'b0;
        ram_we  = 4'b0000;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    bad_d   = req_bad;
                    word_d  = addr_i[ADDR_WIDTH+1:2];
                    wdata_d = wdata_i;
                    sel_d   = sel_i;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ACCESS;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_we  = (we_q && !bad_q) ? sel_q : 4'b0000;
                ram_re  = !we_q && !bad_q;
                // A failed load must present zero, a store leaves the last load visible.
                if (!we_q) begin
                    rzero_d = bad_q;
                end
                ready_d = 1'b1;
                err_d   = bad_q;
                state_d = RESP;
            end
            RESP: begin
                ready_d = 1'b0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rzero_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rzero_q <= rzero_d;
        end
    end

    // Request holding registers are always written in IDLE before use.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        bad_q   <= bad_d;
        word_q  <= word_d;
        wdata_q <= wdata_d;
        sel_q   <= sel_d;
    end

    dmem_bram #(.ADDR_WIDTH(ADDR_WIDTH)) u_bram (
        .clk     (clk),
        .re      (ram_re),
        .we      (ram_we),
        .addr    (word_q),
        .wdata   (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign rdata_o = rzero_q ? 32'd0 : ram_rdata;
    assign ready_o = ready_q;
    assign err_o   = err_q;
    assign stall_o = req_i & ~ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 1, 0, 4) driven by
// a vector table, hand-written corner sequences and random traffic.
module tb_dmem_responder;

    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  sel   [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        err   [3];
    logic        stall [3];

    int wc [3] = '{1, 0, 4};
    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [3][2**AW];
    logic [3:0]  legal_list [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [21];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .sel_i(sel[0]), .rdata_o(rdata[0]), .ready_o(ready[0]),
        .err_o(err[0]), .stall_o(stall[0]));

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .sel_i(sel[1]), .rdata_o(rdata[1]), .ready_o(ready[1]),
        .err_o(err[1]), .stall_o(stall[1]));

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(4)) dut2 (
        .clk(clk), .rst(rst), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]),
        .wdata_i(wdata[2]), .sel_i(sel[2]), .rdata_o(rdata[2]), .ready_o(ready[2]),
        .err_o(err[2]), .stall_o(stall[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: error if sel is not a legal pattern or any address bit above the RAM is set.
    task automatic model_apply(input int k, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               output logic [31:0] exp_rd, output logic exp_err);
        bit legal = 0;
        int idx;
        foreach (legal_list[j]) if (s == legal_list[j]) legal = 1;
        exp_err = !legal || ((a / (32'd4 * (32'd1 << AW))) != 0);
        idx = int'((a / 4) % (32'd1 << AW));
        exp_rd = 32'd0;
        if (!exp_err) begin
            if (w) begin
                for (int l = 0; l < 4; l++)
                    if (s[l]) mdl[k][idx][8*l +: 8] = d[8*l +: 8];
            end else begin
                exp_rd = mdl[k][idx];
            end
        end
    endtask

    // Called at a negedge with the instance idle; returns at a negedge, instance idle again.
    task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic chk_rd, input logic [31:0] exp_rd,
                       input logic exp_err, input string name);
        int lat = 0;
        bit got = 0;
        bit stall_ok;
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; sel[k] = s;
        #1;
        stall_ok = (stall[k] === 1'b1);
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ready[k] === 1'b1) got = 1;
            else if (stall[k] !== 1'b1) stall_ok = 0;
        end
        check({name, " latency"}, 32'(lat), 32'(wc[k] + 2));
        check({name, " stall"}, 32'(stall_ok), 32'd1);
        if (got) begin
            if (chk_rd) check({name, " rdata"}, rdata[k], exp_rd);
            check({name, " err"}, 32'(err[k]), 32'(exp_err));
        end
        req[k] = 1'b0;
        @(negedge clk);
        check({name, " pulse"}, 32'(ready[k]), 32'd0);
    endtask

    initial begin
        logic [31:0] erd;
        logic        eerr;
        logic [31:0] a, d;
        logic [3:0]  s;
        logic        w;
        int          lat;
        bit          got;

        tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,   32'h0,        4'b1111, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h10,   32'h00AA0000, 4'b0100, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 32'h10,   32'h0,        4'b1111, 32'hDEAABEEF, 1'b0};
        tbl[4]  = '{1'b1, 32'h10,   32'hFFFFFFFF, 4'b0101, 32'h0,        1'b1};
        tbl[5]  = '{1'b0, 32'h10,   32'h0,        4'b1111, 32'hDEAABEEF, 1'b0};
        tbl[6]  = '{1'b0, 32'h00010000, 32'h0,    4'b1111, 32'h0,        1'b1};
        tbl[7]  = '{1'b1, 32'h14,   32'hAABBCCDD, 4'b1111, 32'h0,        1'b0};
        tbl[8]  = '{1'b1, 32'h14,   32'h00001122, 4'b0011, 32'h0,        1'b0};
        tbl[9]  = '{1'b0, 32'h14,   32'h0,        4'b0001, 32'hAABB1122, 1'b0};
        tbl[10] = '{1'b1, 32'h14,   32'h55000000, 4'b1000, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 32'h14,   32'h0,        4'b1111, 32'h55BB1122, 1'b0};
        tbl[12] = '{1'b1, 32'h10,   32'h000000FF, 4'b0001, 32'h0,        1'b0};
        tbl[13] = '{1'b0, 32'h10,   32'h0,        4'b1111, 32'hDEAABEFF, 1'b0};
        tbl[14] = '{1'b1, 32'h10,   32'h00003300, 4'b0010, 32'h0,        1'b0};
        tbl[15] = '{1'b0, 32'h10,   32'h0,        4'b1111, 32'hDEAA33FF, 1'b0};
        tbl[16] = '{1'b1, 32'h10,   32'h12340000, 4'b1100, 32'h0,        1'b0};
        tbl[17] = '{1'b0, 32'h10,   32'h0,        4'b1111, 32'h123433FF, 1'b0};
        tbl[18] = '{1'b1, 32'h18,   32'h0,        4'b0000, 32'h0,        1'b1};
        tbl[19] = '{1'b1, 32'h1010, 32'h0,        4'b1111, 32'h0,        1'b1};
        tbl[20] = '{1'b0, 32'h10,   32'h0,        4'b1111, 32'h123433FF, 1'b0};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0; sel[k] = 4'd0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset ready%0d", k), 32'(ready[k]), 32'd0);
            check($sformatf("reset err%0d", k), 32'(err[k]), 32'd0);
            check($sformatf("reset rdata%0d", k), rdata[k], 32'd0);
            check($sformatf("reset stall%0d", k), 32'(stall[k]), 32'd0);
        end

        foreach (tbl[i]) begin
            model_apply(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sel, erd, eerr);
            txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sel, !tbl[i].we,
                tbl[i].exp_rd, tbl[i].exp_err, $sformatf("vec%0d", i));
        end

        // Withdrawal: req drops one cycle after a store is accepted.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hCAFEF00D; sel[0] = 4'b1111;
        @(negedge clk);
        req[0] = 1'b0; we[0] = 1'b0; wdata[0] = 32'd0; sel[0] = 4'b0000;
        lat = 1; got = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ready[0] === 1'b1) got = 1;
        end
        check("withdraw latency", 32'(lat), 32'd3);
        @(negedge clk);
        model_apply(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'b1111, erd, eerr);
        txn(0, 1'b0, 32'h30, 32'h0, 4'b1111, 1'b1, 32'hCAFEF00D, 1'b0, "withdraw load");

        // Zero wait states with a request held through RESP.
        model_apply(1, 1'b1, 32'h40, 32'h0BADF00D, 4'b1111, erd, eerr);
        txn(1, 1'b1, 32'h40, 32'h0BADF00D, 4'b1111, 1'b0, 32'h0, 1'b0, "b2b store");
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40; sel[1] = 4'b1111;
        lat = 0; got = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ready[1] === 1'b1) got = 1;
        end
        check("b2b first latency", 32'(lat), 32'd2);
        addr[1] = 32'h44;
        wdata[1] = 32'h0;
        @(negedge clk);
        check("b2b idle ready", 32'(ready[1]), 32'd0);
        check("b2b idle stall", 32'(stall[1]), 32'd1);
        lat = 1; got = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ready[1] === 1'b1) got = 1;
        end
        check("b2b second latency", 32'(lat), 32'd3);
        req[1] = 1'b0;
        @(negedge clk);

        // Reset during the second WAIT cycle of a store (WAIT_CYCLES = 4).
        model_apply(2, 1'b1, 32'h20, 32'h11111111, 4'b1111, erd, eerr);
        txn(2, 1'b1, 32'h20, 32'h11111111, 4'b1111, 1'b0, 32'h0, 1'b0, "rst prior store");
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h12345678; sel[2] = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req[2] = 1'b0;
        @(negedge clk);
        check("rst ready next", 32'(ready[2]), 32'd0);
        rst = 1'b0;
        got = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready[2] === 1'b1) got = 1;
        end
        check("rst no pulse", 32'(got), 32'd0);
        txn(2, 1'b0, 32'h20, 32'h0, 4'b1111, 1'b1, 32'h11111111, 1'b0, "rst reload");

        // Random traffic against the reference model on each instance.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                d = $urandom;
                model_apply(k, 1'b1, 32'h200 + 32'(4 * i), d, 4'b1111, erd, eerr);
                txn(k, 1'b1, 32'h200 + 32'(4 * i), d, 4'b1111, 1'b0, 32'h0, 1'b0,
                    $sformatf("init%0d_%0d", k, i));
            end
            for (int n = 0; n < 40; n++) begin
                a = 32'h200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(12, 31));
                if ($urandom_range(0, 3) == 0) s = 4'($urandom_range(0, 15));
                else s = legal_list[$urandom_range(0, 6)];
                w = 1'($urandom_range(0, 1));
                d = $urandom;
                model_apply(k, w, a, d, s, erd, eerr);
                txn(k, w, a, d, s, !w, erd, eerr, $sformatf("rand%0d_%0d", k, n));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
